// File: rtl/ex_mdu.sv
// ex_mdu: multi-cycle multiply/divide unit holding architectural HI/LO.
// Results are computed at issue into shadow registers and committed when the latency counter expires.
module ex_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] in_A,
  input  logic [31:0] in_B,
  output logic        busy,
  output logic        md_hazard,
  output logic [31:0] out_HI,
  output logic [31:0] out_LO
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MC = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DC = CW'(DIV_CYCLES);

  logic [31:0]   r_hi, r_lo, r_shi, r_slo;
  logic [CW-1:0] r_cnt;
  logic [31:0]   w_hi_nxt, w_lo_nxt, w_shi_nxt, w_slo_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_idle, w_go;
  logic [63:0]   w_prod, w_res;
  logic [31:0]   w_da, w_db, w_q, w_r, w_quo, w_rem;

  // One divider serves both flavours: signed div runs on magnitudes and fixes signs afterwards
  always_comb begin
    w_prod = op[0] ? {32'b0, in_A} * {32'b0, in_B}
                   : {{32{in_A[31]}}, in_A} * {{32{in_B[31]}}, in_B};
    w_da   = (~op[0] & in_A[31]) ? -in_A : in_A;
    w_db   = (~op[0] & in_B[31]) ? -in_B : in_B;
    w_q    = w_da / w_db;
    w_r    = w_da % w_db;
    w_quo  = (~op[0] & (in_A[31] ^ in_B[31])) ? -w_q : w_q;
    w_rem  = (~op[0] & in_A[31]) ? -w_r : w_r;
    w_res  = ~op[1] ? w_prod : (in_B == 32'b0) ? {in_A, 32'hFFFF_FFFF} : {w_rem, w_quo};
  end

  always_comb begin
    w_idle    = (r_cnt == '0);
    w_go      = w_idle & start & ~op[2];
    w_cnt_nxt = w_go ? (op[1] ? DC : MC) : w_idle ? '0 : r_cnt - CW'(1);
    w_hi_nxt  = (r_cnt == CW'(1)) ? r_shi : (w_idle & start & (op == 3'd4)) ? in_A : r_hi;
    w_lo_nxt  = (r_cnt == CW'(1)) ? r_slo : (w_idle & start & (op == 3'd5)) ? in_A : r_lo;
    w_shi_nxt = w_go ? w_res[63:32] : r_shi;
    w_slo_nxt = w_go ? w_res[31:0] : r_slo;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_shi <= '0;
      r_slo <= '0;
      r_cnt <= '0;
    end else begin
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      r_shi <= w_shi_nxt;
      r_slo <= w_slo_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    busy      = (r_cnt != '0);
    md_hazard = (start & ~op[2]) | busy;
    out_HI    = r_hi;
    out_LO    = r_lo;
  end
endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: directed and random checks of ex_mdu against a plain-arithmetic HI/LO model.
module tb_ex_mdu;
  localparam int MULT = 5;
  localparam int DIV  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] in_A = 32'd0, in_B = 32'd0;
  logic        busy, md_hazard;
  logic [31:0] out_HI, out_LO;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  int          errors = 0, checks = 0;

  ex_mdu #(.MULT_CYCLES(MULT), .DIV_CYCLES(DIV)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .in_A(in_A), .in_B(in_B),
    .busy(busy), .md_hazard(md_hazard), .out_HI(out_HI), .out_LO(out_LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference semantics straight from the arithmetic rules, using 64-bit integers
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      3'd0: begin q = sa * sb; m_hi = q[63:32]; m_lo = q[31:0]; end
      3'd1: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd2, 3'd3: begin
        if (b == 32'd0) begin m_hi = a; m_lo = 32'hFFFF_FFFF; end
        else if (o == 3'd2) begin q = sa / sb; r = sa % sb; m_hi = r[31:0]; m_lo = q[31:0]; end
        else begin p = ua / ub; m_lo = p[31:0]; p = ua % ub; m_hi = p[31:0]; end
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endfunction

  // Issue one op; optionally inject a stray start (op ko, data kv) during busy cycle k
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int k, input logic [2:0] ko, input logic [31:0] kv);
    logic [31:0] oh, ol;
    int n;
    oh = m_hi;
    ol = m_lo;
    @(negedge clk);
    start = 1'b1; op = o; in_A = a; in_B = b;
    #1 chk("hazard_issue", {31'b0, md_hazard}, {31'b0, (o <= 3'd3)});
    @(posedge clk);
    #1 start = 1'b0;
    model(o, a, b);
    if (o > 3'd3) begin
      chk("busy_short", {31'b0, busy}, 32'd0);
      chk("hi_short", out_HI, m_hi);
      chk("lo_short", out_LO, m_lo);
      return;
    end
    n = o[1] ? DIV : MULT;
    for (int i = 0; i < n; i++) begin
      chk("busy_run", {31'b0, busy}, 32'd1);
      chk("hazard_run", {31'b0, md_hazard}, 32'd1);
      chk("hi_hold", out_HI, oh);
      chk("lo_hold", out_LO, ol);
      if (i == k) begin start = 1'b1; op = ko; in_A = kv; end
      @(posedge clk);
      #1 start = 1'b0;
    end
    chk("busy_done", {31'b0, busy}, 32'd0);
    chk("hi_commit", out_HI, m_hi);
    chk("lo_commit", out_LO, m_lo);
  endtask

  initial begin
    logic [2:0] ro;
    logic [31:0] ra, rb;
    repeat (2) @(posedge clk);
    #1 chk("rst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk) reset = 1'b1;
    #1 chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("idle_hazard", {31'b0, md_hazard}, 32'd0);
    chk("idle_hi", out_HI, 32'd0);
    chk("idle_lo", out_LO, 32'd0);

    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, -1, 3'd0, 32'd0);
    chk("mult_hi", out_HI, 32'hFFFF_FFFF);
    chk("mult_lo", out_LO, 32'hFFFF_FFFA);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 3'd0, 32'd0);
    chk("multu_hi", out_HI, 32'hFFFF_FFFE);
    chk("multu_lo", out_LO, 32'h0000_0001);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, -1, 3'd0, 32'd0);
    chk("div_hi", out_HI, 32'hFFFF_FFFF);
    chk("div_lo", out_LO, 32'hFFFF_FFFD);
    run_op(3'd3, 32'd7, 32'd0, -1, 3'd0, 32'd0);
    chk("divz_hi", out_HI, 32'd7);
    chk("divz_lo", out_LO, 32'hFFFF_FFFF);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, 3'd0, 32'd0);
    chk("ovf_hi", out_HI, 32'd0);
    chk("ovf_lo", out_LO, 32'h8000_0000);

    // stray mtlo on the third busy cycle, then mthi right after busy drops
    run_op(3'd0, 32'd2, 32'd3, 2, 3'd5, 32'd9);
    chk("stray_hi", out_HI, 32'd0);
    chk("stray_lo", out_LO, 32'd6);
    run_op(3'd4, 32'h1234, 32'd0, -1, 3'd0, 32'd0);
    chk("mthi_val", out_HI, 32'h1234);
    // start sampled on the commit edge itself must be ignored
    run_op(3'd1, 32'd5, 32'd5, MULT - 1, 3'd4, 32'hDEAD);
    chk("edge_ign_hi", out_HI, 32'd0);
    run_op(3'd6, 32'h5555, 32'h1, -1, 3'd0, 32'd0);
    run_op(3'd5, 32'hABCD, 32'd0, -1, 3'd0, 32'd0);

    // async reset in the fourth busy cycle of a divide
    @(negedge clk);
    start = 1'b1; op = 3'd3; in_A = 32'd100; in_B = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1 chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_hi", out_HI, 32'd0);
    chk("arst_lo", out_LO, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (DIV + 2) @(posedge clk);
    #1 chk("post_rst_busy", {31'b0, busy}, 32'd0);
    chk("post_rst_hi", out_HI, 32'd0);
    chk("post_rst_lo", out_LO, 32'd0);

    for (int t = 0; t < 30; t++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
      run_op(ro, ra, rb, -1, 3'd0, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ex_mdu.md
# ex_mdu

Multi-cycle multiply/divide unit in the Execute stage, directly upstream of the Memory stage. It executes `mult`, `multu`, `div`, `divu`, `mthi` and `mtlo`, and holds the architectural HI/LO registers. Execute forwards `out_HI`/`out_LO` as the result of `mfhi`/`mflo` into the EX/MEM ALUout path. The Decode hazard logic uses `busy`/`md_hazard` to stall any HI/LO-touching instruction while an operation is in flight.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- start  in  1  issue strobe; sampled at rising edge
- op  in  3  0=mult 1=multu 2=div 3=divu 4=mthi 5=mtlo 6,7=reserved (no-op)
- in_A  in  32  rs operand (dividend/multiplicand/mthi-mtlo data)
- in_B  in  32  rt operand (divisor/multiplier)
- busy  out  1  registered; 1 while a mult/div is in flight
- md_hazard  out  1  combinational, start & (op≤3) | busy; drives Decode stall
- out_HI  out  32  architectural HI
- out_LO  out  32  architectural LO

## Operation
- One clock domain; reset is asynchronous and active-low, exactly as above.
- State: HI, LO, shadow registers sHI/sLO, down-counter cnt (width ≥ clog2(max(MULT_CYCLES,DIV_CYCLES)+1)).
- Reset (reset=0): HI=LO=sHI=sLO=0, cnt=0, busy=0. Takes effect without a clock edge and aborts any in-flight operation; nothing is committed.
- States: IDLE (cnt=0), RUN (cnt>0). busy = (cnt≠0).
- IDLE, start=1, op∈{0..3}: the result is computed from in_A/in_B and captured into sHI/sLO, cnt ← MULT_CYCLES or DIV_CYCLES. The next state is RUN.
- IDLE, start=1, op=4: HI ← in_A at the same edge. op=5: LO ← in_A at the same edge. cnt stays 0.
- IDLE, start=1, op=6/7: no state change.
- RUN: cnt decrements each edge. On the edge where cnt=1: HI←sHI, LO←sLO, cnt←0.
- RUN, start=1 (any op): ignored. Decode must not issue during busy; the unit must never corrupt sHI/sLO or cnt due to such a start.
- Arithmetic:
  - mult: signed 32×32→64, {HI,LO}=product.
  - multu: unsigned 32×32→64, {HI,LO}=product.
  - div: signed, truncating toward zero. LO=quotient, HI=remainder; the remainder sign follows the dividend.
  - divu: unsigned; LO=quotient, HI=remainder.
- Divide by zero (div or divu, in_B=0): LO=32'hFFFFFFFF, HI=in_A. Full latency still applies.
- Signed overflow (div, in_A=32'h80000000, in_B=32'hFFFFFFFF): LO=32'h80000000, HI=0.
- out_HI/out_LO always show the committed HI/LO, never the shadow values.

## Timing
- Mult/div latency: start sampled at edge T. busy=1 during cycles T+1 … T+N (N=MULT_CYCLES or DIV_CYCLES). New HI/LO are visible from edge T+N. busy=0 after edge T+N.
- Back-to-back issue: a new start is accepted in the cycle after busy falls, i.e. sampled at edge T+N+1 at the earliest. A start sampled at edge T+N itself is ignored.
- mthi/mtlo: one-cycle; the value is visible on out_HI/out_LO right after the sampling edge. busy never asserts.
- md_hazard is asserted combinationally in the start cycle of mult/div, so Decode stalls without a bubble gap.
- Reset assertion mid-RUN: busy drops and HI/LO read 0 immediately (asynchronous). After reset deassertion the first edge may accept a start.

## Test plan
- Reset then idle: after reset release, busy=0, out_HI=out_LO=0, md_hazard=0 with start=0.
- mult, A=32'hFFFFFFFE (−2), B=3, MULT_CYCLES=5: busy high exactly 5 cycles; then HI=32'hFFFFFFFF, LO=32'hFFFFFFFA. HI/LO must stay at their old values during busy.
- multu, A=B=32'hFFFFFFFF: HI=32'hFFFFFFFE, LO=32'h00000001 after 5 cycles.
- div A=−7, B=2: LO=32'hFFFFFFFD, HI=32'hFFFFFFFF after 10 cycles. Second case, divu A=7, B=0: LO=32'hFFFFFFFF, HI=7. Third case, div 32'h80000000 / −1: LO=32'h80000000, HI=0.
- Start during busy: issue mult 2×3, then mtlo 9 at the 3rd busy cycle. The mtlo must be ignored; final HI=0, LO=6. Next, mthi 32'h1234 at the first idle cycle gives HI=32'h1234 on the following cycle.
- Async reset mid-div: assert reset at the 4th busy cycle between edges. busy, HI and LO must go to 0 before the next edge, and no commit may occur after release.
